// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch engine. Owns the program counter, issues one read at a
// time to the memory bank (variable-latency ack handshake), holds the fetched
// word together with its address and offers it to the controller over a
// valid/ready handshake. A PC-relative redirect (taken branch) is applied at
// the moment the controller consumes the held instruction.
//
// Optional feature macro: FETCH_HALT_EN
//   When defined, a fetched word whose top nibble equals HALT_OP is not
//   delivered; the unit freezes in a HALT state (halted=1) until reset.
//   When undefined, no opcode is decoded and halted is tied low.
//
// Ports:
//   CLK              in   system clock, rising edge
//   reset            in   synchronous, active-high
//   enable           in   permits new fetches
//   mem_addr         out  fetch address (registered)
//   mem_read         out  read request, held until mem_ack
//   mem_data         in   read data, valid with mem_ack
//   mem_ack          in   memory completion strobe
//   inst             out  held instruction
//   inst_pc          out  address of the held instruction
//   inst_valid       out  inst/inst_pc valid
//   inst_ready       in   controller consumes the instruction
//   redirect         in   branch taken, sampled only on consume
//   redirect_offset  in   signed redirect offset
//   pc               out  address of the next fetch
//   halted           out  halt state flag
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int              ADDR_W     = 8,
    parameter int              INST_W     = 16,
    parameter int              OFF_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter logic [3:0]      HALT_OP    = 4'hF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic [INST_W-1:0] mem_data,
    input  logic              mem_ack,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [OFF_W-1:0]  redirect_offset,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

`ifdef FETCH_HALT_EN
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
`endif

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic              mem_read_reg, mem_read_next;
    logic [INST_W-1:0] inst_reg, inst_next;
    logic [ADDR_W-1:0] inst_pc_reg, inst_pc_next;
    logic              inst_valid_reg, inst_valid_next;

    // Sign-extended offset; the size cast of a signed operand replicates the
    // sign bit, and also works when OFF_W == ADDR_W.
    logic [ADDR_W-1:0] offset_ext;
    logic [ADDR_W-1:0] consume_pc;

    assign offset_ext = ADDR_W'(signed'(redirect_offset));
    // pc already holds inst_pc+1 in HOLD, so the non-redirect case keeps it.
    assign consume_pc = redirect ? (inst_pc_reg + ADDR_W'(1) + offset_ext) : pc_reg;

`ifdef FETCH_HALT_EN
    logic halted_reg, halted_next;
    logic is_halt_word;
    assign is_halt_word = (mem_data[INST_W-1:INST_W-4] == HALT_OP);
`endif

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_ADDR;
            mem_addr_reg   <= '0;
            mem_read_reg   <= 1'b0;
            inst_reg       <= '0;
            inst_pc_reg    <= '0;
            inst_valid_reg <= 1'b0;
`ifdef FETCH_HALT_EN
            halted_reg     <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            mem_addr_reg   <= mem_addr_next;
            mem_read_reg   <= mem_read_next;
            inst_reg       <= inst_next;
            inst_pc_reg    <= inst_pc_next;
            inst_valid_reg <= inst_valid_next;
`ifdef FETCH_HALT_EN
            halted_reg     <= halted_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        mem_addr_next   = mem_addr_reg;
        mem_read_next   = mem_read_reg;
        inst_next       = inst_reg;
        inst_pc_next    = inst_pc_reg;
        inst_valid_next = inst_valid_reg;
`ifdef FETCH_HALT_EN
        halted_next     = halted_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next    = FETCH;
                    mem_addr_next = pc_reg;
                    mem_read_next = 1'b1;
                end
            end

            // Request is held until ack; enable and redirect do not matter here.
            FETCH: begin
                if (mem_ack) begin
                    mem_read_next = 1'b0;
                    inst_next     = mem_data;
                    inst_pc_next  = mem_addr_reg;
`ifdef FETCH_HALT_EN
                    if (is_halt_word) begin
                        // Word and address kept for debug, never delivered.
                        halted_next = 1'b1;
                        state_next  = HALT;
                    end else begin
                        inst_valid_next = 1'b1;
                        pc_next         = pc_reg + ADDR_W'(1);
                        state_next      = HOLD;
                    end
`else
                    inst_valid_next = 1'b1;
                    pc_next         = pc_reg + ADDR_W'(1);
                    state_next      = HOLD;
`endif
                end
            end

            HOLD: begin
                if (inst_ready) begin
                    inst_valid_next = 1'b0;
                    pc_next         = consume_pc;
                    if (enable) begin
                        // Back-to-back: the new pc goes straight onto the bus.
                        state_next    = FETCH;
                        mem_addr_next = consume_pc;
                        mem_read_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

`ifdef FETCH_HALT_EN
            HALT: begin
                // Frozen until reset.
            end
`endif

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_addr   = mem_addr_reg;
    assign mem_read   = mem_read_reg;
    assign inst       = inst_reg;
    assign inst_pc    = inst_pc_reg;
    assign inst_valid = inst_valid_reg;
    assign pc         = pc_reg;
`ifdef FETCH_HALT_EN
    assign halted     = halted_reg;
`else
    assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Scoreboard bench for fetch_unit (default parameters). The consumer driver
// decides stalls, redirects and offsets; for each consume it computes the next
// program address with plain modular arithmetic and pushes the expected
// request address and the expected delivered (address, word) pair. A memory
// responder serves requests with random latency (and injects stray acks while
// no request is pending), checking each request address. A monitor checks
// every delivered instruction and the stability of held instructions.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  mem_addr;
    logic        mem_read;
    logic [15:0] mem_data;
    logic        mem_ack;
    logic [15:0] inst;
    logic [7:0]  inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [7:0]  redirect_offset;
    logic [7:0]  pc;
    logic        halted;

    always #5 CLK = ~CLK;

    fetch_unit dut (
        .CLK             (CLK),
        .reset           (reset),
        .enable          (enable),
        .mem_addr        (mem_addr),
        .mem_read        (mem_read),
        .mem_data        (mem_data),
        .mem_ack         (mem_ack),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .redirect        (redirect),
        .redirect_offset (redirect_offset),
        .pc              (pc),
        .halted          (halted)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  req_q[$];
    exp_t        deliv_q[$];
    logic [15:0] mem_model [256];
    bit          inhibit  = 1'b0;
    bit          en_run   = 1'b0;
    int          cur_addr = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Next program address after consuming the instruction at cur.
    function automatic int next_addr(int cur, bit redir, logic [7:0] off);
        int soff;
        soff = (off >= 8'd128) ? int'(off) - 256 : int'(off);
        return (cur + 1 + (redir ? soff : 0) + 256) % 256;
    endfunction

    task automatic expect_fetch(int a);
        exp_t e;
        e.addr = a[7:0];
        e.data = mem_model[a];
        req_q.push_back(a[7:0]);
        deliv_q.push_back(e);
    endtask

    // Wait for a held instruction, stall, then consume it.
    task automatic consume(int stall, bit redir, logic [7:0] off);
        int waited = 0;
        while (inst_valid !== 1'b1 && waited < 200) begin
            @(negedge CLK);
            waited++;
        end
        if (inst_valid !== 1'b1) begin
            fail_now("consume_wait_timeout");
            return;
        end
        repeat (stall) begin
            // Redirect without ready must have no effect.
            inst_ready      = 1'b0;
            redirect        = 1'($urandom_range(0, 1));
            redirect_offset = 8'($urandom);
            @(negedge CLK);
        end
        inst_ready      = 1'b1;
        redirect        = redir;
        redirect_offset = off;
        cur_addr = next_addr(cur_addr, redir, off);
        expect_fetch(cur_addr);
        @(negedge CLK);
        inst_ready      = 1'b0;
        redirect        = 1'b0;
        redirect_offset = 8'($urandom);
        if (!en_run) begin
            // enable held high: request must follow the consume immediately.
            check("b2b_mem_read", mem_read, 1'b1);
            check("b2b_mem_addr", mem_addr, cur_addr[7:0]);
        end
    endtask

    // Memory responder.
    initial begin
        int         cnt  = 0;
        bit         busy = 1'b0;
        logic [7:0] la   = '0;
        forever begin
            @(negedge CLK);
            if (inhibit) begin
                busy = 1'b0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                busy    = 1'b0;
            end else if (mem_read) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = $urandom_range(0, 3);
                    if (req_q.size() == 0) begin
                        fail_now("unexpected_request");
                    end else begin
                        la = req_q.pop_front();
                        check("mem_addr", mem_addr, la);
                    end
                    la = mem_addr;
                end else begin
                    check("mem_addr_stable", mem_addr, la);
                end
                if (cnt == 0) begin
                    mem_ack  = 1'b1;
                    mem_data = mem_model[mem_addr];
                end else begin
                    cnt--;
                end
            end else if ($urandom_range(0, 5) == 0) begin
                // Stray ack with no request pending: must be ignored.
                mem_ack  = 1'b1;
                mem_data = 16'($urandom);
            end
        end
    end

    // Random enable while the random phase runs.
    initial begin
        forever begin
            @(negedge CLK);
            if (en_run) enable = ($urandom_range(0, 3) != 0);
        end
    end

    // Delivery monitor.
    initial begin
        bit          pv = 1'b0;
        logic [15:0] pi = '0;
        logic [7:0]  pp = '0;
        exp_t        e;
        forever begin
            @(negedge CLK);
            if (reset) begin
                pv = 1'b0;
            end else begin
`ifndef FETCH_HALT_EN
                if (halted !== 1'b0) fail_now("halted_tied_low");
`endif
                if (inst_valid && !pv) begin
                    if (deliv_q.size() == 0) begin
                        fail_now("unexpected_delivery");
                    end else begin
                        e = deliv_q.pop_front();
                        $display("deliver inst_pc=%02h inst=%04h pc=%02h", inst_pc, inst, pc);
                        check("inst", inst, e.data);
                        check("inst_pc", inst_pc, e.addr);
                        check("pc_after_fetch", pc, 8'(e.addr + 8'd1));
                    end
                end else if (inst_valid && pv) begin
                    check("hold_inst", inst, pi);
                    check("hold_inst_pc", inst_pc, pp);
                    check("hold_no_read", mem_read, 1'b0);
                end
                pv = inst_valid;
                pi = inst;
                pp = inst_pc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int waited;
        for (int i = 0; i < 256; i++) mem_model[i] = 16'($urandom);
`ifdef FETCH_HALT_EN
        for (int i = 0; i < 256; i++)
            if (mem_model[i][15:12] == 4'hF) mem_model[i][15:12] = 4'h7;
        mem_model[4] = 16'h7000;
`else
        mem_model[4] = 16'hF000;
`endif
        mem_model[0] = 16'h83A0;

        reset = 1'b1; enable = 1'b0; mem_ack = 1'b0; mem_data = '0;
        inst_ready = 1'b0; redirect = 1'b0; redirect_offset = '0;
        repeat (3) @(negedge CLK);
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_mem_addr", mem_addr, 8'h00);
        check("rst_pc", pc, 8'h00);
        check("rst_inst", inst, 16'h0000);
        check("rst_inst_pc", inst_pc, 8'h00);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_halted", halted, 1'b0);

        // Directed: sequential fetch, stall, redirects, wrap.
        cur_addr = 0;
        expect_fetch(0);
        reset  = 1'b0;
        enable = 1'b1;
        consume(5, 1'b0, 8'h00);   // 00 -> 01
        consume(0, 1'b0, 8'h00);   // 01 -> 02
        consume(1, 1'b0, 8'h00);   // 02 -> 03
        consume(0, 1'b0, 8'h00);   // 03 -> 04
        consume(0, 1'b1, 8'h0B);   // 04 -> 10
        consume(1, 1'b1, 8'hFE);   // 10 -> 0F
        consume(0, 1'b0, 8'h00);   // 0F -> 10
        consume(2, 1'b1, 8'h05);   // 10 -> 16
        consume(0, 1'b1, 8'hE7);   // 16 -> FE
        consume(0, 1'b1, 8'h03);   // FE -> 02
        consume(0, 1'b1, 8'hFC);   // 02 -> FF
        consume(0, 1'b0, 8'h00);   // FF -> 00

        // Random phase.
        en_run = 1'b1;
        for (int n = 0; n < 150; n++)
            consume($urandom_range(0, 3), ($urandom_range(0, 2) == 0), 8'($urandom));

        // Reset during an outstanding request.
        en_run = 1'b0;
        enable = 1'b1;
        waited = 0;
        while (inst_valid !== 1'b1 && waited < 200) begin
            @(negedge CLK);
            waited++;
        end
        if (inst_valid !== 1'b1) fail_now("pre_reset_wait_timeout");
        inhibit    = 1'b1;
        mem_ack    = 1'b0;
        inst_ready = 1'b1;
        @(negedge CLK);
        inst_ready = 1'b0;
        @(negedge CLK);
        check("pre_reset_mem_read", mem_read, 1'b1);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge CLK);
        reset = 1'b0;
        check("mid_rst_mem_read", mem_read, 1'b0);
        check("mid_rst_pc", pc, 8'h00);
        check("mid_rst_inst_valid", inst_valid, 1'b0);
        check("mid_rst_mem_addr", mem_addr, 8'h00);
        @(negedge CLK);
        mem_ack  = 1'b1;
        mem_data = 16'h1234;
        @(negedge CLK);
        mem_ack = 1'b0;
        repeat (2) begin
            check("late_ack_mem_read", mem_read, 1'b0);
            check("late_ack_inst_valid", inst_valid, 1'b0);
            check("late_ack_pc", pc, 8'h00);
            check("late_ack_inst", inst, 16'h0000);
            @(negedge CLK);
        end

        // Restart from the reset address.
        req_q.delete();
        deliv_q.delete();
        cur_addr = 0;
        expect_fetch(0);
        inhibit = 1'b0;
        en_run  = 1'b1;
        for (int n = 0; n < 3; n++)
            consume($urandom_range(0, 2), ($urandom_range(0, 1) == 0), 8'($urandom));
        repeat (4) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
